// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding and fetch constants for fetch_unit
package fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FAULT = 2'd2} state_t;
    localparam int PC_INC      = 4;
    localparam int INSTR_WIDTH = 32;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a single output slot and redirect; FETCH_MISALIGN_CHECK_EN enables misaligned-target fault
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = INSTR_WIDTH,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_enable_read,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_data_valid,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  fetch_fault
);
    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_target;
    logic                  w_req, w_capture, w_misalign;

    assign w_req           = (r_state == FETCH) && (!instr_valid || instr_ready);
    assign mem_enable_read = w_req;
    assign w_capture       = w_req && mem_data_valid && !redirect_valid;
    assign mem_address     = {2'b00, r_pc[ADDR_WIDTH-1:2]};

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_target    = redirect_pc;
    assign w_misalign  = redirect_pc[1:0] != 2'b00;
    assign fetch_fault = r_state == FAULT;
`else
    assign w_target    = redirect_pc & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
    assign w_misalign  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // State register; reset parks the FSM in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Redirect wins from any state; IDLE always moves on after one cycle
    always_comb begin
        w_state_next = redirect_valid ? (w_misalign ? FAULT : FETCH)
                                      : (r_state == IDLE ? FETCH : r_state);
    end

    // PC and output slot: redirect flushes, capture refills, accept drains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_pc        <= w_target;
            instr_valid <= 1'b0;
        end else if (w_capture) begin
            instr       <= mem_data;
            instr_pc    <= r_pc;
            instr_valid <= 1'b1;
            r_pc        <= r_pc + ADDR_WIDTH'(PC_INC);
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a fetch-stream model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_address;
    logic        mem_enable_read;
    logic [31:0] mem_data = '0;
    logic        mem_data_valid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_address    (mem_address),
        .mem_enable_read(mem_enable_read),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        mdv;
        logic        e_val;
        logic [31:0] e_ipc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fault;
    } vec_t;

    vec_t tbl[24];

    function automatic logic [31:0] mem_fn(input logic [31:0] w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc, input logic mdv,
                                input logic e_val, input logic [31:0] e_ipc, input logic e_req,
                                input logic [31:0] e_addr, input logic e_fault);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.mdv = mdv; v.e_val = e_val;
        v.e_ipc = e_ipc; v.e_req = e_req; v.e_addr = e_addr; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " instr_valid"}, 32'(instr_valid), 0);
        chk({tag, " mem_enable_read"}, 32'(mem_enable_read), 0);
        chk({tag, " fetch_fault"}, 32'(fetch_fault), 0);
        chk({tag, " instr"}, instr, 0);
        chk({tag, " instr_pc"}, instr_pc, 0);
        chk({tag, " mem_address"}, mem_address, 0);
    endtask

    logic        m_fetch, m_valid, m_pend, m_req, m_deliver;
    logic [31:0] m_fpc, m_ipc;
    int          m_lat;

    initial begin
`ifdef FETCH_MISALIGN_CHECK_EN
        localparam logic F = 1'b1;
`else
        localparam logic F = 1'b0;
`endif
        //             rdy  rv  rpc           mdv val ipc           req addr          fault
        tbl[0]  = mk(1, 0, 0,            1, 0, 0,            0, 0,            0);
        tbl[1]  = mk(1, 0, 0,            1, 0, 0,            1, 0,            0);
        tbl[2]  = mk(1, 0, 0,            1, 1, 0,            1, 1,            0);
        tbl[3]  = mk(1, 0, 0,            1, 1, 4,            1, 2,            0);
        tbl[4]  = mk(1, 0, 0,            1, 1, 8,            1, 3,            0);
        tbl[5]  = mk(0, 0, 0,            1, 1, 12,           0, 4,            0);
        tbl[6]  = mk(0, 0, 0,            1, 1, 12,           0, 4,            0);
        tbl[7]  = mk(0, 0, 0,            1, 1, 12,           0, 4,            0);
        tbl[8]  = mk(1, 0, 0,            0, 1, 12,           1, 4,            0);
        tbl[9]  = mk(1, 0, 0,            0, 0, 0,            1, 4,            0);
        tbl[10] = mk(1, 0, 0,            0, 0, 0,            1, 4,            0);
        tbl[11] = mk(1, 0, 0,            1, 0, 0,            1, 4,            0);
        tbl[12] = mk(1, 1, 32'h40,       1, 1, 16,           1, 5,            0);
        tbl[13] = mk(1, 0, 0,            1, 0, 0,            1, 32'h10,       0);
        tbl[14] = mk(1, 0, 0,            0, 1, 32'h40,       1, 32'h11,       0);
        tbl[15] = mk(1, 1, 32'hFFFFFFFC, 0, 0, 0,            1, 32'h11,       0);
        tbl[16] = mk(1, 0, 0,            1, 0, 0,            1, 32'h3FFFFFFF, 0);
        tbl[17] = mk(1, 0, 0,            1, 1, 32'hFFFFFFFC, 1, 0,            0);
        tbl[18] = mk(1, 0, 0,            0, 1, 0,            1, 1,            0);
        tbl[19] = mk(1, 1, 32'h42,       0, 0, 0,            1, 1,            0);
        tbl[20] = mk(1, 0, 0,            0, 0, 0,            !F, 32'h10,      F);
        tbl[21] = mk(1, 1, 32'h80,       1, 0, 0,            !F, 32'h10,      F);
        tbl[22] = mk(1, 0, 0,            1, 0, 0,            1, 32'h20,       0);
        tbl[23] = mk(1, 0, 0,            0, 1, 32'h80,       1, 32'h21,       0);

        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed table, zero-latency memory
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            instr_ready    = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            mem_data_valid = tbl[i].mdv;
            #1 mem_data    = mem_fn(mem_address);
            #1;
            chk($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_val));
            chk($sformatf("row%0d mem_enable_read", i), 32'(mem_enable_read), 32'(tbl[i].e_req));
            chk($sformatf("row%0d mem_address", i), mem_address, tbl[i].e_addr);
            chk($sformatf("row%0d fetch_fault", i), 32'(fetch_fault), 32'(tbl[i].e_fault));
            if (tbl[i].e_val) begin
                chk($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].e_ipc);
                chk($sformatf("row%0d instr", i), instr, mem_fn(tbl[i].e_ipc >> 2));
            end
        end

        // Randomized run with variable memory latency
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_data_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_fetch = 0; m_valid = 0; m_pend = 0; m_fpc = 0; m_ipc = 0; m_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            instr_ready    = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            redirect_pc    = (($urandom % 8) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
`else
            redirect_pc    = (($urandom % 8) == 0) ? 32'hFFFFFFF9 : $urandom;
`endif
            #1;
            m_req = m_fetch && (!m_valid || instr_ready);
            chk("rnd mem_enable_read", 32'(mem_enable_read), 32'(m_req));
            chk("rnd instr_valid", 32'(instr_valid), 32'(m_valid));
            chk("rnd fetch_fault", 32'(fetch_fault), 0);
            if (m_valid) begin
                chk("rnd instr_pc", instr_pc, m_ipc);
                chk("rnd instr", instr, mem_fn(m_ipc >> 2));
            end
            if (m_req) chk("rnd mem_address", mem_address, m_fpc >> 2);
            if (mem_enable_read) begin
                if (!m_pend) begin
                    m_pend = 1;
                    m_lat  = $urandom % 3;
                end
                if (m_lat == 0) begin
                    mem_data_valid = 1'b1;
                    mem_data       = mem_fn(mem_address);
                    m_pend         = 0;
                end else begin
                    m_lat--;
                    mem_data_valid = 1'b0;
                    mem_data       = $urandom;
                end
            end else begin
                m_pend         = 0;
                mem_data_valid = ($urandom % 2) == 1;
                mem_data       = $urandom;
            end
            if (redirect_valid) m_pend = 0;
            m_deliver = m_req && mem_data_valid;
            if (redirect_valid) begin
                m_fpc   = redirect_pc & 32'hFFFFFFFC;
                m_valid = 0;
                m_fetch = 1;
            end else if (!m_fetch) begin
                m_fetch = 1;
            end else if (m_deliver) begin
                m_ipc   = m_fpc;
                m_fpc   = m_fpc + 32'd4;
                m_valid = 1;
            end else if (m_valid && instr_ready) begin
                m_valid = 0;
            end
        end

        // Reset arriving mid-request with a response on the bus
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        #1;
        mem_data_valid = 1'b1;
        mem_data       = 32'hDEADBEEF;
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        @(negedge clk);
        chk("reset hold instr_valid", 32'(instr_valid), 0);
        chk("reset hold instr", instr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-PC width and memory address width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch byte address.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_address  output  ADDR_WIDTH  word index to instruction memory.
REQ-007 SHALL have port mem_enable_read  output  1  read request to instruction memory.
REQ-008 SHALL have port mem_data  input  DATA_WIDTH  instruction word from memory.
REQ-009 SHALL have port mem_data_valid  input  1  mem_data valid this cycle (same or later cycle than request).
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-011 SHALL have port redirect_pc  input  ADDR_WIDTH  redirect target byte address.
REQ-012 SHALL have port instr  output  DATA_WIDTH  fetched instruction to decode.
REQ-013 SHALL have port instr_pc  output  ADDR_WIDTH  byte PC of instr.
REQ-014 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-015 SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-016 SHALL have port fetch_fault  output  1  misaligned-target fault flag.

Function
REQ-017 SHALL hold byte PC register pc; mem_address SHALL equal pc >> 2 (zero-filled top bits).
REQ-018 SHALL implement states IDLE, FETCH, FAULT; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-019 In FETCH, mem_enable_read SHALL be 1 iff output slot empty (instr_valid=0) or slot drains this cycle (instr_valid & instr_ready); 0 in IDLE and FAULT.
REQ-020 On mem_enable_read & mem_data_valid without redirect: instr<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4 next edge; sustains 1 instr/cycle with zero-latency memory.
REQ-021 Request SHALL stay asserted with mem_address stable until mem_data_valid (multi-cycle memory); mem_data_valid while mem_enable_read=0 SHALL be ignored.
REQ-022 instr/instr_pc SHALL be held stable while instr_valid & !instr_ready; instr_valid cleared on accept when no new word captured.
REQ-023 redirect_valid SHALL have highest priority: pc<=redirect_pc, instr_valid<=0, any same-cycle mem_data discarded, in-flight request abandoned; fetch from new pc next cycle.
REQ-024 redirect_valid simultaneous with instr_ready: the held instr counts as accepted, no new instr presented that cycle.
REQ-025 pc+4 SHALL wrap modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-026 redirect_valid in IDLE SHALL load pc and proceed to FETCH as normal.

Reset
REQ-027 While rst=0: pc=RESET_PC, state=IDLE, instr=0, instr_pc=0, instr_valid=0, mem_enable_read=0, fetch_fault=0, asynchronously.
REQ-028 Reset mid-fetch SHALL abandon request; no word captured from a response arriving during reset.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 SHALL enter FAULT, fetch_fault=1, no requests, instr_valid=0, until an aligned redirect returns to FETCH with fetch_fault=0.
REQ-030 Macro undefined: redirect_pc[1:0] SHALL be forced to 0 on load, FAULT unreachable, fetch_fault tied 0.

Structure
REQ-031 Shared package SHALL hold state encoding typedef (IDLE/FETCH/FAULT), PC increment constant 4, instruction width constant.
REQ-032 Single module; no sub-module; PC next-value logic inline.

Verification
REQ-033 Reset release, zero-latency memory, ready=1 -> first request cycle 2, instr_pc 0,4,8,12 on consecutive cycles.
REQ-034 instr_ready=0 for 3 cycles with instr_valid=1 -> instr/instr_pc unchanged, mem_enable_read=0, resumes next cycle after ready.
REQ-035 mem_data_valid delayed 2 cycles -> mem_address held, single capture, pc advances once by 4.
REQ-036 redirect_valid with redirect_pc=0x40 same cycle as mem_data_valid -> data dropped, next instr_pc=0x40.
REQ-037 pc=0xFFFFFFFC fetch -> next mem_address 0, instr_pc 0x00000000.
REQ-038 With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x42 -> fetch_fault=1, no requests; redirect 0x80 -> fault cleared, fetch 0x80.
